mem_responder: RTL

// - Target-side end of the mem_if protocol: a word-organised memory that accepts

---
 rtl/mem_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-organised memory target for the mem_if protocol: single-cycle writes, pipelined reads with RD_LAT latency.
// Optional error statistics counter (err_cnt) is enabled by defining MEM_ERR_STATS_EN.
module mem_responder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err
`ifdef MEM_ERR_STATS_EN
    ,
    output logic [15:0]       err_cnt
`endif
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    logic [DATA_W-1:0] mem [DEPTH];

    logic          legal;
    logic [AW-1:0] idx;

    logic              vld_q [RD_LAT];
    logic              vld_d [RD_LAT];
    logic              err_q [RD_LAT];
    logic              err_d [RD_LAT];
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] dat_d [RD_LAT];

    // Any address at or beyond the array end is rejected; upper bits never alias.
    always_comb begin
        legal = (addr[1:0] == 2'b00) && (addr < LIMIT);
        idx   = addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (wr_en && legal) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        for (int s = 0; s < RD_LAT; s++) begin
            vld_d[s] = 1'b0;
            err_d[s] = 1'b0;
            dat_d[s] = dat_q[s];
        end
        // Slot entry: a read colliding with a write is dropped but still flagged.
        vld_d[0] = rd_en && !wr_en;
        err_d[0] = (rd_en && wr_en) || ((rd_en || wr_en) && !legal);
        if (vld_d[0]) begin
            dat_d[0] = legal ? mem[idx] : '0;
        end
        // Data only advances with a valid slot so the output holds between returns.
        for (int s = 1; s < RD_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            err_d[s] = err_q[s-1];
            if (vld_q[s-1]) begin
                dat_d[s] = dat_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < RD_LAT; s++) begin
                vld_q[s] <= 1'b0;
                err_q[s] <= 1'b0;
                dat_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < RD_LAT; s++) begin
                vld_q[s] <= vld_d[s];
                err_q[s] <= err_d[s];
                dat_q[s] <= dat_d[s];
            end
        end
    end

    assign rdata  = dat_q[RD_LAT-1];
    assign rvalid = vld_q[RD_LAT-1];
    assign err    = err_q[RD_LAT-1];

`ifdef MEM_ERR_STATS_EN
    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_q[RD_LAT-1] && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
